prienc_arb_reg: RTL and testbench
=================================

Name: prienc_arb_reg

Overview:
- Parametrised, registered successor to the 4-to-2 priority encoder.
- Encodes an N-bit request vector into a binary index, a one-hot grant and flags.
- Two selectable modes: fixed priority (highest index wins) and round-robin (rotating pointer).
- Result is held in an output register with a valid/ready handshake, so it can sit between a request source and a downstream consumer in pipelined datapaths.

Parameters:
- N, 8, number of request inputs; legal range N >= 2, need not be a power of 2.
- W, $clog2(N), width of the encoded index; derived, never overridden.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- mode  input  1  0 = fixed priority (highest index wins), 1 = round-robin.
- req  input  N  request vector, bit i = requester i.
- out_ready  input  1  downstream accepts the current result.
- out_valid  output  1  output register holds a result.
- out_code  output  W  binary index of the granted requester.
- out_grant  output  N  one-hot grant (bit out_code set).
- out_multi  output  1  more than one req bit was set when sampled.

Behaviour:
- Reset (rst_n low, asynchronous, takes effect immediately without a clock):
  - out_valid=0, out_code=0, out_grant=0, out_multi=0, RR pointer ptr=0.
  - A pending unaccepted result is discarded.
  - Outputs stay at reset values until the first rising edge after rst_n deasserts.
- Load condition: load = !out_valid || out_ready. This is evaluated every cycle.
- On a clock edge with load=1:
  - If req != 0: out_valid<=1, out_code<=winner, out_grant<=(1<<winner), out_multi<=(popcount(req)>1).
  - If req == 0: out_valid<=0. out_code, out_grant and out_multi keep their previous values; they are don't-care while out_valid=0.
- On a clock edge with load=0 (out_valid=1, out_ready=0):
  - All outputs and ptr hold.
  - req is ignored. Requests are not latched; sources must hold req until served.
- Latency: a result appears on the edge where req is sampled with load=1, so outputs are valid the next cycle. Full throughput is one result per cycle when out_ready is held high.
- Fixed mode (mode=0):
  - winner = highest set index of req. For N=4 this matches the existing 4-to-2 encoder.
  - ptr is never modified in this mode.
- Round-robin mode (mode=1):
  - winner = first set bit scanning upward from index ptr: ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
  - On a load edge with req != 0, ptr <= (winner == N-1) ? 0 : winner+1. The wrap is explicit, which matters for non-power-of-2 N.
  - ptr is unchanged on load edges with req == 0 and on stall edges.
- Mode switching:
  - mode is sampled together with req on load edges.
  - Switching modes does not reset ptr. Round-robin resumes from the last stored pointer.
- Invariants:
  - out_grant is always one-hot or zero.
  - When out_valid=1, out_grant == 1<<out_code.
  - out_multi=0 whenever exactly one req bit was sampled.
- Simultaneous req change and out_ready=1 in the same cycle: the new req is sampled on that edge. There is no bubble.

Test Plan:
- Reset + fixed mode, N=8, out_ready=1, req=8'b0010_0110 -> next cycle out_valid=1, out_code=5, out_grant=8'h20, out_multi=1. Then req=8'h00 -> out_valid=0.
- Round-robin, N=8, out_ready=1, req=8'hFF held for 10 cycles from reset -> out_code sequence 0,1,2,...,7,0,1, out_multi=1 throughout.
- Backpressure: RR mode, req=8'h81, out_ready=0 for 3 cycles after the first result -> out_code=0 held stable with out_valid=1 and ptr unchanged. Then out_ready=1 -> next result out_code=7, then 0.
- Non-power-of-2: N=5 (W=3), RR mode, req=5'b10001, out_ready=1 -> codes 0,4,0,4. ptr wraps from 4 to 0 and never takes the values 5-7.
- Mode switch: RR mode, grant code 2 with req=8'h0C, then mode=0, req=8'h0F -> code 3. Then mode=1, req=8'h0F -> code 3, because ptr was still 3 from the earlier RR grant.
- Async reset mid-stall: out_valid=1, out_ready=0, rst_n pulsed low between edges -> out_valid=0, out_code=0, out_grant=0 immediately. After release, RR order restarts from index 0.

Source files
------------

// File: rtl/prienc_arb_reg.sv
// prienc_arb_reg: registered N-input priority encoder / arbiter.
// Encodes a request vector into a binary index, a one-hot grant and a
// "more than one request" flag. It uses either fixed priority (highest index
// wins) or round-robin (rotating pointer). The result is held in an output
// register behind a valid/ready handshake.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   mode       0 = fixed priority, 1 = round-robin
//   req        request vector, bit i = requester i
//   out_ready  downstream accepts the current result
//   out_valid  output register holds a result
//   out_code   binary index of the granted requester
//   out_grant  one-hot grant, bit out_code set
//   out_multi  more than one req bit was set when sampled
module prienc_arb_reg #(
   parameter  int unsigned N = 8,
   localparam int unsigned W = $clog2(N)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         mode,
   input  logic [N-1:0] req,
   input  logic         out_ready,
   output logic         out_valid,
   output logic [W-1:0] out_code,
   output logic [N-1:0] out_grant,
   output logic         out_multi
);

   logic         out_valid_q, out_valid_d;
   logic [W-1:0] out_code_q,  out_code_d;
   logic [N-1:0] out_grant_q, out_grant_d;
   logic         out_multi_q, out_multi_d;
   logic [W-1:0] ptr_q,       ptr_d;

   logic         load;
   logic [W-1:0] fix_win;
   logic [W-1:0] rr_win;
   logic [W-1:0] win;
   logic [N-1:0] win_grant;
   logic [W-1:0] ptr_next;
   int           idx;
   logic [W-1:0] idx_w;

   // Winner selection for both modes
   always_comb begin
      fix_win = '0;
      rr_win  = '0;
      idx     = 0;
      idx_w   = '0;
      // Ascending scan: the last hit is the highest set index
      for (int i = 0; i < int'(N); i++) begin
         if (req[W'(i)]) fix_win = W'(i);
      end
      // Descending offset scan from ptr: the last hit is the nearest at/after ptr
      for (int k = int'(N) - 1; k >= 0; k--) begin
         idx = int'(ptr_q) + k;
         if (idx >= int'(N)) idx = idx - int'(N);
         idx_w = W'(idx);
         if (req[idx_w]) rr_win = idx_w;
      end
      win            = mode ? rr_win : fix_win;
      win_grant      = '0;
      win_grant[win] = 1'b1;
      // Explicit wrap so non-power-of-2 N never reaches an illegal pointer value
      ptr_next       = (win == W'(N - 1)) ? '0 : win + W'(1);
   end

   // Output register and pointer next-state
   always_comb begin
      out_valid_d = out_valid_q;
      out_code_d  = out_code_q;
      out_grant_d = out_grant_q;
      out_multi_d = out_multi_q;
      ptr_d       = ptr_q;
      load        = !out_valid_q || out_ready;
      if (load) begin
         if (req != '0) begin
            out_valid_d = 1'b1;
            out_code_d  = win;
            out_grant_d = win_grant;
            out_multi_d = ($countones(req) > 1);
            if (mode) ptr_d = ptr_next;
         end else begin
            out_valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_code_q  <= '0;
         out_grant_q <= '0;
         out_multi_q <= 1'b0;
         ptr_q       <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_code_q  <= out_code_d;
         out_grant_q <= out_grant_d;
         out_multi_q <= out_multi_d;
         ptr_q       <= ptr_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_code  = out_code_q;
   assign out_grant = out_grant_q;
   assign out_multi = out_multi_q;

endmodule

// File: tb/tb_prienc_arb_reg.sv
// Testbench for prienc_arb_reg: an N=8 instance checked through a scoreboard
// with randomized handshake traffic, plus an N=5 instance for the
// non-power-of-2 round-robin wrap.
module tb_prienc_arb_reg;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       mode;
   logic [7:0] req;
   logic       out_ready;
   logic       out_valid;
   logic [2:0] out_code;
   logic [7:0] out_grant;
   logic       out_multi;

   logic       rst5_n;
   logic       mode5;
   logic [4:0] req5;
   logic       ready5;
   logic       valid5;
   logic [2:0] code5;
   logic [4:0] grant5;
   logic       multi5;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      int code;
      int grant;
      int multi;
   } exp_t;

   exp_t sb[$];
   bit   m_valid;
   int   m_ptr;

   always #5 clk = ~clk;

   prienc_arb_reg #(.N(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .mode(mode), .req(req), .out_ready(out_ready),
      .out_valid(out_valid), .out_code(out_code), .out_grant(out_grant),
      .out_multi(out_multi)
   );

   prienc_arb_reg #(.N(5)) u_dut5 (
      .clk(clk), .rst_n(rst5_n), .mode(mode5), .req(req5), .out_ready(ready5),
      .out_valid(valid5), .out_code(code5), .out_grant(grant5),
      .out_multi(multi5)
   );

   task automatic chk(input string name, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
      end
   endtask

   // Reference: priority rules written directly from the arbitration definition
   function automatic int ref_winner(input logic [7:0] r, input int n, input bit m, input int p);
      if (!m) begin
         for (int i = n - 1; i >= 0; i--) if (r[i]) return i;
      end else begin
         for (int k = 0; k < n; k++) if (r[(p + k) % n]) return (p + k) % n;
      end
      return -1;
   endfunction

   function automatic int popcnt(input logic [7:0] r);
      int c = 0;
      for (int i = 0; i < 8; i++) if (r[i]) c++;
      return c;
   endfunction

   // Model of one clock edge for the N=8 instance; pushes the expected result
   task automatic model_edge();
      exp_t e;
      int   w;
      if (!m_valid || out_ready) begin
         if (req != 8'h00) begin
            w       = ref_winner(req, 8, mode, m_ptr);
            e.code  = w;
            e.grant = 1 << w;
            e.multi = (popcnt(req) > 1) ? 1 : 0;
            sb.push_back(e);
            if (mode) m_ptr = (w + 1) % 8;
            m_valid = 1'b1;
         end else begin
            m_valid = 1'b0;
         end
      end
   endtask

   task automatic step(input bit m, input logic [7:0] r, input bit rdy);
      @(negedge clk);
      mode = m; req = r; out_ready = rdy;
      @(posedge clk);
      model_edge();
   endtask

   // Async reset pulse between edges while a result is stalled
   task automatic reset_pulse();
      @(negedge clk);
      req = 8'h00; out_ready = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      chk("async_rst_valid", int'(out_valid), 0);
      chk("async_rst_code",  int'(out_code),  0);
      chk("async_rst_grant", int'(out_grant), 0);
      chk("async_rst_multi", int'(out_multi), 0);
      sb.delete();
      m_valid = 1'b0;
      m_ptr   = 0;
      #1 rst_n = 1'b1;
      @(posedge clk);
      model_edge();
   endtask

   // Monitor: just before each rising edge compare the held result to the scoreboard
   initial begin
      forever begin
         @(negedge clk);
         #4;
         if (rst_n === 1'b1) begin
            chk("valid", int'(out_valid), (sb.size() != 0) ? 1 : 0);
            if (sb.size() != 0) begin
               chk("code",  int'(out_code),  sb[0].code);
               chk("grant", int'(out_grant), sb[0].grant);
               chk("multi", int'(out_multi), sb[0].multi);
               if (out_ready) void'(sb.pop_front());
            end
         end
      end
   end

   // N=5 round-robin wrap and random traffic with out_ready held high
   task automatic run_n5();
      int   p = 0;
      bit   have = 1'b0;
      bit   e_valid = 1'b0;
      int   e_code = 0;
      int   e_multi = 0;
      int   w;
      logic [7:0] r8;
      logic [4:0] r;
      bit   m;
      for (int i = 0; i < 160; i++) begin
         @(negedge clk);
         if (have) begin
            chk("n5_valid", int'(valid5), e_valid ? 1 : 0);
            if (e_valid) begin
               chk("n5_code",  int'(code5),  e_code);
               chk("n5_grant", int'(grant5), 1 << e_code);
               chk("n5_multi", int'(multi5), e_multi);
            end
         end
         if (i < 8) begin
            r = 5'b10001; m = 1'b1;
         end else begin
            r = 5'($urandom); m = 1'($urandom);
         end
         req5 = r; mode5 = m;
         r8   = {3'b000, r};
         if (r != 5'b0) begin
            w       = ref_winner(r8, 5, m, p);
            e_valid = 1'b1;
            e_code  = w;
            e_multi = (popcnt(r8) > 1) ? 1 : 0;
            if (m) p = (w + 1) % 5;
         end else begin
            e_valid = 1'b0;
         end
         have = 1'b1;
      end
   endtask

   task automatic run_n8();
      bit m;
      logic [7:0] r;
      // Fixed mode: highest index wins, then idle request drops valid
      step(1'b0, 8'b0010_0110, 1'b1);
      step(1'b0, 8'h00, 1'b1);
      step(1'b0, 8'h00, 1'b1);
      // Round-robin, all requesting: codes sweep 0..7 then wrap
      for (int i = 0; i < 10; i++) step(1'b1, 8'hFF, 1'b1);
      step(1'b0, 8'h00, 1'b1);
      // Backpressure holds the result and the pointer
      step(1'b1, 8'h81, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b1, 8'h81, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b1, 8'h81, 1'b1);
      // Mode switch keeps the round-robin pointer
      step(1'b1, 8'h0C, 1'b1);
      step(1'b0, 8'h0F, 1'b1);
      step(1'b1, 8'h0F, 1'b1);
      step(1'b0, 8'h00, 1'b1);
      // Reset in the middle of a stall, then round-robin restarts at 0
      step(1'b1, 8'hFF, 1'b1);
      step(1'b1, 8'hFF, 1'b1);
      step(1'b1, 8'hFF, 1'b0);
      reset_pulse();
      for (int i = 0; i < 4; i++) step(1'b1, 8'hFF, 1'b1);
      // Random traffic
      for (int i = 0; i < 1500; i++) begin
         m = 1'($urandom);
         case ($urandom_range(0, 3))
            0:       r = 8'h00;
            1:       r = 8'h01 << $urandom_range(0, 7);
            default: r = 8'($urandom);
         endcase
         step(m, r, ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0);
      end
      // Drain with a bounded number of cycles
      for (int i = 0; i < 4 && sb.size() != 0; i++) step(1'b0, 8'h00, 1'b1);
      step(1'b0, 8'h00, 1'b1);
      chk("drain_empty", sb.size(), 0);
   endtask

   initial begin
      rst_n = 1'b0; rst5_n = 1'b0;
      mode = 1'b0; req = 8'h00; out_ready = 1'b0;
      mode5 = 1'b0; req5 = 5'b0; ready5 = 1'b1;
      m_valid = 1'b0; m_ptr = 0;
      #12;
      chk("rst_valid", int'(out_valid), 0);
      chk("rst_code",  int'(out_code),  0);
      chk("rst_grant", int'(out_grant), 0);
      chk("rst_multi", int'(out_multi), 0);
      chk("rst5_valid", int'(valid5), 0);
      @(negedge clk);
      rst_n = 1'b1; rst5_n = 1'b1;
      fork
         run_n8();
         run_n5();
      join
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not complete, got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
